// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: decode/execute control bundle between the nRisc front end and the sequencer
interface pipeline_sequencer_if;
  logic       dec_valid;
  logic [2:0] dec_rs_a;
  logic [2:0] dec_rs_b;
  logic       dec_uses_b;
  logic [2:0] dec_rd;
  logic       dec_writes;
  logic       jump_taken;
  logic       halt_req;
  logic       issue;
  logic       stall_fetch;
  logic       bubble_ex;
  logic       flush;
  logic       halted;
  logic [2:0] state;
  logic [7:0] stall_count;
  modport master (
    output dec_valid, dec_rs_a, dec_rs_b, dec_uses_b, dec_rd, dec_writes, jump_taken, halt_req,
    input  issue, stall_fetch, bubble_ex, flush, halted, state, stall_count
  );
  modport slave (
    input  dec_valid, dec_rs_a, dec_rs_b, dec_uses_b, dec_rd, dec_writes, jump_taken, halt_req,
    output issue, stall_fetch, bubble_ex, flush, halted, state, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: RAW-hazard scoreboard, jump flush, halt drain and stall counter for the nRisc pipeline
// Ports: clock/reset (sync, active-high); bus.slave carries decode fields, jump/halt requests in,
// and issue/stall_fetch/bubble_ex/flush/halted/state/stall_count out.
module pipeline_sequencer #(
  parameter int WB_LATENCY   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, HALT} state_t;
  state_t     st;
  logic [2:0] cnt [8];
  logic [2:0] fcnt;
  logic [7:0] sc;
  logic       hazard;
  logic       pending;
  always_comb begin
    hazard  = bus.dec_valid & (cnt[bus.dec_rs_a] != 3'd0 | (bus.dec_uses_b & cnt[bus.dec_rs_b] != 3'd0));
    pending = 1'b0;
    for (int i = 0; i < 8; i++) pending = pending | (cnt[i] != 3'd0);
  end
  assign bus.issue       = ~reset & st == RUN & bus.dec_valid & ~hazard & ~bus.jump_taken;
  assign bus.stall_fetch = reset | (st == RUN ? hazard : st != FLUSH);
  assign bus.bubble_ex   = ~bus.issue;
  assign bus.flush       = ~reset & st == FLUSH;
  assign bus.halted      = ~reset & st == HALT & ~pending;
  assign bus.state       = st;
  assign bus.stall_count = sc;
  always_ff @(posedge clock) begin
    if (reset) begin
      st   <= IDLE;
      fcnt <= 3'd0;
      sc   <= 8'd0;
      for (int i = 0; i < 8; i++) cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < 8; i++)
        cnt[i] <= (bus.issue & bus.dec_writes & bus.dec_rd == 3'(i)) ? 3'(WB_LATENCY) :
                  cnt[i] != 3'd0 ? cnt[i] - 3'd1 : cnt[i];
      if (st == STALL && sc != 8'hff) sc <= sc + 8'd1;
      case (st)
        IDLE: st <= RUN;
        RUN: begin
          if (bus.jump_taken) begin
            st   <= FLUSH;
            fcnt <= 3'(FLUSH_CYCLES);
          end else if (bus.halt_req) st <= HALT;
          else if (hazard) st <= STALL;
        end
        STALL: begin
          if (bus.jump_taken) begin
            st   <= FLUSH;
            fcnt <= 3'(FLUSH_CYCLES);
          end else if (!hazard) st <= RUN;
        end
        FLUSH: begin
          if (bus.jump_taken) fcnt <= 3'(FLUSH_CYCLES);
          else if (fcnt == 3'd1) st <= RUN;
          else fcnt <= fcnt - 3'd1;
        end
        default: st <= st;
      endcase
    end
  end
endmodule
